// File: rtl/spi_reg_bank.sv
// Register-bank SPI slave (mode 0, 32-bit frames) sampled in the clk domain.
// Define SPI_REG_BANK_ERRCNT_EN to add the read-only aborted-frame counter at 0x04.
module spi_reg_bank #(
  parameter logic [23:0] MAGIC = 24'hC0FFEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       dout,
  output logic [7:0] reg_spi_mux,
  output logic [3:0] reg_led
);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, DATA, FULL} state_t;

  state_t      state, state_next;
  logic [2:0]  sclk_sync, cs_sync;
  logic [1:0]  mosi_sync;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
  logic [5:0]  bit_cnt;
  logic [23:0] shift_in;
  logic [23:0] shift_out;
  logic [7:0]  cmd;
  logic        overrun;
  logic [23:0] scratch;
  logic [6:0]  rd_addr;
  logic [23:0] rd_value;
  logic        commit;
  logic        abort;
`ifdef SPI_REG_BANK_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  // Synchronisers are deliberately not reset so a frame in progress at reset
  // keeps cs low and holds the FSM in WAIT_IDLE.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[1:0], spi_clk};
    cs_sync   <= {cs_sync[1:0], spi_cs};
    mosi_sync <= {mosi_sync[0], spi_mosi};
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign mosi      = mosi_sync[1];

  assign commit = (state == FULL) && cmd[7] && !overrun &&
                  ((cmd[6:0] == 7'h00) || (cmd[6:0] == 7'h01) || (cmd[6:0] == 7'h03));
  assign abort  = (state == CMD) || (state == DATA) || ((state == FULL) && overrun);

  // Address is complete only once the 8th bit arrives, so it is taken from the shifter plus mosi.
  always_comb begin
    rd_addr  = {shift_in[5:0], mosi};
    rd_value = 24'd0;
    case (rd_addr)
      7'h00: rd_value = {20'd0, reg_led};
      7'h01: rd_value = {16'd0, reg_spi_mux};
      7'h02: rd_value = MAGIC;
      7'h03: rd_value = scratch;
`ifdef SPI_REG_BANK_ERRCNT_EN
      7'h04: rd_value = {16'd0, err_cnt};
`endif
      default: rd_value = 24'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (cs_sync[1]) state_next = IDLE;
      IDLE:      if (cs_fall) state_next = CMD;
      CMD: begin
        if (cs_rise) state_next = IDLE;
        else if (sclk_rise && bit_cnt == 6'd7) state_next = DATA;
      end
      DATA: begin
        if (cs_rise) state_next = IDLE;
        else if (sclk_rise && bit_cnt == 6'd31) state_next = FULL;
      end
      FULL:      if (cs_rise) state_next = IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  // A cs rising edge takes priority over any spi_clk edge seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 6'd0;
      shift_in    <= 24'd0;
      shift_out   <= 24'd0;
      cmd         <= 8'd0;
      overrun     <= 1'b0;
      dout        <= 1'b0;
      reg_led     <= 4'd0;
      reg_spi_mux <= 8'd0;
      scratch     <= 24'd0;
`ifdef SPI_REG_BANK_ERRCNT_EN
      err_cnt     <= 8'd0;
`endif
    end else if (state != WAIT_IDLE) begin
      if (cs_rise) begin
        dout <= 1'b0;
        if (commit) begin
          case (cmd[6:0])
            7'h00:   reg_led     <= shift_in[3:0];
            7'h01:   reg_spi_mux <= shift_in[7:0];
            7'h03:   scratch     <= shift_in;
            default: ;
          endcase
        end
`ifdef SPI_REG_BANK_ERRCNT_EN
        if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              bit_cnt   <= 6'd0;
              shift_in  <= 24'd0;
              shift_out <= 24'd0;
              cmd       <= 8'd0;
              overrun   <= 1'b0;
              dout      <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[22:0], mosi};
              bit_cnt  <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) begin
                cmd <= {shift_in[6:0], mosi};
                if (!shift_in[6]) shift_out <= rd_value;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[22:0], mosi};
              bit_cnt  <= bit_cnt + 6'd1;
            end else if (sclk_fall && !cmd[7]) begin
              dout      <= shift_out[23];
              shift_out <= {shift_out[22:0], 1'b0};
            end
          end
          FULL: begin
            if (sclk_rise) overrun <= 1'b1;
            else if (sclk_fall) dout <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios plus random frames
// against a register-map model; honours SPI_REG_BANK_ERRCNT_EN like the RTL.
module tb_spi_reg_bank;

  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       dout;
  logic [7:0] reg_spi_mux;
  logic [3:0] reg_led;

  int total = 0;
  int bad   = 0;

  logic [3:0]  m_led;
  logic [7:0]  m_mux;
  logic [23:0] m_scratch;
  logic [7:0]  m_err;
  logic        dout_high;

  spi_reg_bank dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .dout       (dout),
    .reg_spi_mux(reg_spi_mux),
    .reg_led    (reg_led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!spi_cs && dout === 1'b1) dout_high = 1'b1;
  end

  function automatic logic [23:0] model_read(input logic [6:0] a);
    case (a)
      7'h00: return {20'd0, m_led};
      7'h01: return {16'd0, m_mux};
      7'h02: return 24'hC0FFEE;
      7'h03: return m_scratch;
`ifdef SPI_REG_BANK_ERRCNT_EN
      7'h04: return {16'd0, m_err};
`endif
      default: return 24'd0;
    endcase
  endfunction

  task automatic model_frame(input logic [31:0] f, input int nbits);
    if (nbits != 32) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (f[31]) begin
      case (f[30:24])
        7'h00: m_led = f[3:0];
        7'h01: m_mux = f[7:0];
        7'h03: m_scratch = f[23:0];
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_led = 4'd0; m_mux = 8'd0; m_scratch = 24'd0; m_err = 8'd0;
  endtask

  task automatic send_bit(input logic b, output logic sampled);
    spi_mosi = b;
    #HALF;
    sampled = dout;
    spi_clk = 1'b1;
    #HALF;
    spi_clk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] f, input int nbits, output logic [23:0] rd);
    logic s;
    logic b;
    rd = 24'd0;
    dout_high = 1'b0;
    spi_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 32) ? f[31 - i] : 1'($urandom);
      send_bit(b, s);
      if (i >= 8 && i < 32) rd[31 - i] = s;
    end
    #HALF;
    spi_cs = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    model_reset();
    #60;
    rst = 1'b0;
    #100;
    total++; if (dout !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout: got %b expected 0", dout); end
    total++; if (reg_spi_mux !== 8'h00) begin bad++; $display("[TB] FAIL reset_mux: got %h expected 00", reg_spi_mux); end
    total++; if (reg_led !== 4'h0) begin bad++; $display("[TB] FAIL reset_led: got %h expected 0", reg_led); end
  endtask

  task automatic test_write_mux();
    logic [23:0] rd;
    spi_frame(32'h81000004, 32, rd);
    model_frame(32'h81000004, 32);
    total++; if (reg_spi_mux !== m_mux) begin bad++; $display("[TB] FAIL write_mux: got %h expected %h", reg_spi_mux, m_mux); end
    total++; if (dout_high !== 1'b0) begin bad++; $display("[TB] FAIL write_dout_quiet: got %b expected 0", dout_high); end
  endtask

  task automatic test_read_magic();
    logic [23:0] rd;
    spi_frame(32'h02A5A5A5, 32, rd);
    total++; if (rd !== 24'hC0FFEE) begin bad++; $display("[TB] FAIL read_magic: got %h expected c0ffee", rd); end
    total++; if (reg_spi_mux !== m_mux || reg_led !== m_led) begin
      bad++; $display("[TB] FAIL read_no_change: got mux=%h led=%h expected mux=%h led=%h", reg_spi_mux, reg_led, m_mux, m_led);
    end
    total++; if (dout !== 1'b0) begin bad++; $display("[TB] FAIL read_dout_idle: got %b expected 0", dout); end
  endtask

  task automatic test_scratch();
    logic [23:0] rd;
    spi_frame(32'h83123456, 32, rd);
    model_frame(32'h83123456, 32);
    spi_frame(32'h03000000, 32, rd);
    total++; if (rd !== 24'h123456) begin bad++; $display("[TB] FAIL scratch_readback: got %h expected 123456", rd); end
    spi_frame(32'h7F000000, 32, rd);
    total++; if (rd !== 24'h000000) begin bad++; $display("[TB] FAIL unmapped_read: got %h expected 000000", rd); end
  endtask

  task automatic test_truncated();
    logic [23:0] rd;
    spi_frame(32'h810000FF, 20, rd);
    model_frame(32'h810000FF, 20);
    total++; if (reg_spi_mux !== m_mux) begin bad++; $display("[TB] FAIL truncated_mux: got %h expected %h", reg_spi_mux, m_mux); end
`ifdef SPI_REG_BANK_ERRCNT_EN
    spi_frame(32'h04000000, 32, rd);
    total++; if (rd !== {16'd0, m_err}) begin bad++; $display("[TB] FAIL errcnt_read: got %h expected %h", rd, {16'd0, m_err}); end
`else
    spi_frame(32'h04000000, 32, rd);
    total++; if (rd !== 24'd0) begin bad++; $display("[TB] FAIL addr4_unmapped: got %h expected 000000", rd); end
`endif
  endtask

  task automatic test_overrun();
    logic [23:0] rd;
    spi_frame(32'h81000002, 33, rd);
    model_frame(32'h81000002, 33);
    total++; if (reg_spi_mux !== m_mux) begin bad++; $display("[TB] FAIL overrun_mux: got %h expected %h", reg_spi_mux, m_mux); end
  endtask

  task automatic test_random();
    logic [23:0] rd;
    logic [23:0] exp_rd;
    logic [31:0] f;
    logic [6:0]  a;
    int          nbits;
    int          sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      a = (sel == 5) ? 7'($urandom_range(5, 127)) : 7'(sel);
      f = {1'($urandom), a, 24'($urandom)};
      sel = $urandom_range(0, 9);
      nbits = (sel == 0) ? $urandom_range(1, 31) : (sel == 1) ? 33 : 32;
      exp_rd = model_read(a);
      spi_frame(f, nbits, rd);
      model_frame(f, nbits);
      total++; if (reg_led !== m_led || reg_spi_mux !== m_mux) begin
        bad++; $display("[TB] FAIL rand_regs[%0d] frame=%h bits=%0d: got led=%h mux=%h expected led=%h mux=%h",
                        n, f, nbits, reg_led, reg_spi_mux, m_led, m_mux);
      end
      if (!f[31] && nbits == 32) begin
        total++; if (rd !== exp_rd) begin bad++; $display("[TB] FAIL rand_read[%0d] addr=%h: got %h expected %h", n, a, rd, exp_rd); end
      end
      if (f[31]) begin
        total++; if (dout_high !== 1'b0) begin bad++; $display("[TB] FAIL rand_write_dout[%0d]: got %b expected 0", n, dout_high); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] rd;
    logic        s;
    logic [31:0] f;
    spi_frame(32'h810000A5, 32, rd);
    model_frame(32'h810000A5, 32);
    spi_frame(32'h8000000C, 32, rd);
    model_frame(32'h8000000C, 32);
    f = 32'h81000033;
    spi_cs = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(f[31 - i], s);
    rst = 1'b1;
    #20;
    rst = 1'b0;
    model_reset();
    #10;
    total++; if (reg_spi_mux !== 8'h00) begin bad++; $display("[TB] FAIL midreset_mux: got %h expected 00", reg_spi_mux); end
    total++; if (reg_led !== 4'h0) begin bad++; $display("[TB] FAIL midreset_led: got %h expected 0", reg_led); end
    for (int i = 12; i < 32; i++) send_bit(f[31 - i], s);
    #HALF;
    spi_cs = 1'b1;
    #200;
    total++; if (reg_spi_mux !== 8'h00) begin bad++; $display("[TB] FAIL midreset_ignored: got %h expected 00", reg_spi_mux); end
    spi_frame(32'h81000040, 32, rd);
    model_frame(32'h81000040, 32);
    total++; if (reg_spi_mux !== 8'h40) begin bad++; $display("[TB] FAIL post_reset_commit: got %h expected 40", reg_spi_mux); end
  endtask

  initial begin
    test_reset();
    test_write_mux();
    test_read_magic();
    test_scratch();
    test_truncated();
    test_overrun();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
